// File: rtl/mc_main_ctrl_pkg.sv
// mc_pkg: shared state, opcode and datapath-select encodings for the multicycle MIPS controller
package mc_pkg;
  localparam int OPW = 6;
  localparam int STW = 4;
  typedef enum logic [STW-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMM4  = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: controller <-> datapath bundle (status in, selects/enables out)
interface mc_main_ctrl_if;
  import mc_pkg::*;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           iord;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic           memtoreg;
  logic           regdst;
  logic [1:0]     pcsrc;
  logic [1:0]     alu_op;
  logic           irwrite;
  logic           regwrite;
  logic           memwrite;
  logic           pcen;
  logic [STW-1:0] state_o;
  modport master (
    input  opcode, zero, mem_ready,
    output iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, alu_op,
           irwrite, regwrite, memwrite, pcen, state_o
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, alu_op,
           irwrite, regwrite, memwrite, pcen, state_o
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: Moore main control FSM for the multicycle MIPS datapath
module mc_main_ctrl
  import mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mc_main_ctrl_if.master bus
);
  state_t state_q, state_d;
  logic irwrite_r, regwrite_r, memwrite_r, pcwrite, branch;
  // state register, async return to FETCH abandons any in-flight instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  // next-state: memory states stall on mem_ready, DECODE/MEMADR dispatch on opcode
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                         bus.opcode == OP_RTYPE ? EXECUTE :
                         bus.opcode == OP_BEQ   ? BRANCH  :
                         bus.opcode == OP_ADDI  ? ADDIEX  :
                         bus.opcode == OP_J     ? JUMP    : FETCH;
      MEMADR:  state_d = bus.opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // output decode: everything not set in a state stays 0
  always_comb begin
    bus.iord    = 1'b0;
    bus.alusrca = 1'b0;
    bus.alusrcb = SRCB_B;
    bus.memtoreg = 1'b0;
    bus.regdst  = 1'b0;
    bus.pcsrc   = PC_ALU;
    bus.alu_op  = ALU_ADD;
    irwrite_r   = 1'b0;
    regwrite_r  = 1'b0;
    memwrite_r  = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    case (state_q)
      FETCH:   begin bus.alusrcb = SRCB_4; irwrite_r = bus.mem_ready; pcwrite = bus.mem_ready; end
      DECODE:  bus.alusrcb = SRCB_IMM4;
      MEMADR:  begin bus.alusrca = 1'b1; bus.alusrcb = SRCB_IMM; end
      MEMRD:   bus.iord = 1'b1;
      MEMWB:   begin bus.memtoreg = 1'b1; regwrite_r = 1'b1; end
      MEMWR:   begin bus.iord = 1'b1; memwrite_r = 1'b1; end
      EXECUTE: begin bus.alusrca = 1'b1; bus.alu_op = ALU_FUNCT; end
      ALUWB:   begin bus.regdst = 1'b1; regwrite_r = 1'b1; end
      BRANCH:  begin bus.alusrca = 1'b1; bus.alu_op = ALU_SUB; bus.pcsrc = PC_ALUOUT; branch = 1'b1; end
      ADDIEX:  begin bus.alusrca = 1'b1; bus.alusrcb = SRCB_IMM; end
      ADDIWB:  regwrite_r = 1'b1;
      JUMP:    begin bus.pcsrc = PC_JUMP; pcwrite = 1'b1; end
      default: ;
    endcase
  end
  // enables are held off while reset is asserted so no write leaks through
  assign bus.irwrite  = irwrite_r & rst_n;
  assign bus.regwrite = regwrite_r & rst_n;
  assign bus.memwrite = memwrite_r & rst_n;
  assign bus.pcen     = (pcwrite | (branch & bus.zero)) & rst_n;
  assign bus.state_o  = state_q;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_mc_main_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [17:0] sb[$];
  mc_main_ctrl_if bus ();
  mc_main_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // {iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, alu_op, irwrite, regwrite, memwrite, pcen}
  localparam logic [13:0] O_F1  = 14'b0_0_01_0_0_00_00_1_0_0_1;
  localparam logic [13:0] O_F0  = 14'b0_0_01_0_0_00_00_0_0_0_0;
  localparam logic [13:0] O_DEC = 14'b0_0_11_0_0_00_00_0_0_0_0;
  localparam logic [13:0] O_MA  = 14'b0_1_10_0_0_00_00_0_0_0_0;
  localparam logic [13:0] O_MRD = 14'b1_0_00_0_0_00_00_0_0_0_0;
  localparam logic [13:0] O_MWB = 14'b0_0_00_1_0_00_00_0_1_0_0;
  localparam logic [13:0] O_MWR = 14'b1_0_00_0_0_00_00_0_0_1_0;
  localparam logic [13:0] O_EX  = 14'b0_1_00_0_0_00_10_0_0_0_0;
  localparam logic [13:0] O_AWB = 14'b0_0_00_0_1_00_00_0_1_0_0;
  localparam logic [13:0] O_BR1 = 14'b0_1_00_0_0_01_01_0_0_0_1;
  localparam logic [13:0] O_BR0 = 14'b0_1_00_0_0_01_01_0_0_0_0;
  localparam logic [13:0] O_AEX = 14'b0_1_10_0_0_00_00_0_0_0_0;
  localparam logic [13:0] O_IWB = 14'b0_0_00_0_0_00_00_0_1_0_0;
  localparam logic [13:0] O_JMP = 14'b0_0_00_0_0_10_00_0_0_0_1;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
  // drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input logic rn, input logic mr, input logic z, input logic [5:0] op,
                     input logic [3:0] st, input logic [13:0] o);
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.mem_ready = mr;
    bus.zero = z;
    bus.opcode = op;
    sb.push_back({st, o});
  endtask
  // monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    logic [17:0] e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {bus.state_o, bus.iord, bus.alusrca, bus.alusrcb, bus.memtoreg, bus.regdst,
           bus.pcsrc, bus.alu_op, bus.irwrite, bus.regwrite, bus.memwrite, bus.pcen};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL vec%0d state/outs: got %0d/%b want %0d/%b",
                 vectors, g[17:14], g[13:0], e[17:14], e[13:0]);
      end
    end
  end
  initial begin
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.opcode = RT;
    repeat (3) cyc(0, 1, 0, RT, 0, O_F0);
    cyc(1, 1, 0, LW, 0, O_F1);
    cyc(1, 1, 0, LW, 1, O_DEC);
    cyc(1, 1, 0, LW, 2, O_MA);
    cyc(1, 1, 0, LW, 3, O_MRD);
    cyc(1, 1, 0, LW, 4, O_MWB);
    cyc(1, 0, 0, SW, 0, O_F0);
    cyc(1, 1, 0, SW, 0, O_F1);
    cyc(1, 1, 0, SW, 1, O_DEC);
    cyc(1, 1, 0, SW, 2, O_MA);
    cyc(1, 0, 0, SW, 5, O_MWR);
    cyc(1, 0, 0, SW, 5, O_MWR);
    cyc(1, 1, 0, SW, 5, O_MWR);
    cyc(1, 1, 1, BEQ, 0, O_F1);
    cyc(1, 1, 1, BEQ, 1, O_DEC);
    cyc(1, 1, 1, BEQ, 8, O_BR1);
    cyc(1, 1, 0, BEQ, 0, O_F1);
    cyc(1, 1, 0, BEQ, 1, O_DEC);
    cyc(1, 1, 0, BEQ, 8, O_BR0);
    cyc(1, 1, 0, RT, 0, O_F1);
    cyc(1, 1, 0, RT, 1, O_DEC);
    cyc(1, 1, 0, RT, 6, O_EX);
    cyc(1, 1, 0, RT, 7, O_AWB);
    cyc(1, 1, 0, ADDI, 0, O_F1);
    cyc(1, 1, 0, ADDI, 1, O_DEC);
    cyc(1, 1, 0, ADDI, 9, O_AEX);
    cyc(1, 1, 0, ADDI, 10, O_IWB);
    cyc(1, 1, 0, JMP, 0, O_F1);
    cyc(1, 1, 0, JMP, 1, O_DEC);
    cyc(1, 1, 0, JMP, 11, O_JMP);
    cyc(1, 1, 0, BAD, 0, O_F1);
    cyc(1, 1, 0, BAD, 1, O_DEC);
    cyc(1, 1, 0, LW, 0, O_F1);
    cyc(1, 1, 0, LW, 1, O_DEC);
    cyc(1, 1, 0, LW, 2, O_MA);
    cyc(1, 0, 0, LW, 3, O_MRD);
    cyc(0, 1, 0, LW, 0, O_F0);
    cyc(0, 1, 0, LW, 0, O_F0);
    cyc(1, 1, 0, LW, 0, O_F1);
    cyc(1, 1, 0, LW, 1, O_DEC);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath. It drives every datapath mux select (IorD, ALUSrcA, ALUSrcB, MemtoReg, RegDst, PCSrc) and every register/memory write enable, one step per clock.
- It decodes the opcode latched in the instruction register.
- It stalls on an instruction/data memory ready handshake.
- The ALU function decoder (funct -> ALU control) is a separate block fed by alu_op.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width; must hold 12 states.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  OPW  instr[31:26] from instruction register.
- zero  input  1  ALU zero flag (valid in BRANCH state).
- mem_ready  input  1  memory has completed the current read/write this cycle.
- iord  output  1  address mux select: 1 = ALUOut, 0 = PC.
- alusrca  output  1  ALU A select: 1 = register A, 0 = PC.
- alusrcb  output  2  ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- memtoreg  output  1  writeback select: 1 = Data, 0 = ALUOut.
- regdst  output  1  destination register select: 1 = rd, 0 = rt.
- pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_op  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct.
- irwrite  output  1  instruction register enable.
- regwrite  output  1  register file write enable.
- memwrite  output  1  memory write strobe.
- pcen  output  1  PC enable = pcwrite | (branch & zero).
- state_o  output  STW  current state, for debug/trace.

Behaviour:
- Moore FSM. All outputs are combinational from the state register plus the gating terms listed below. No Mealy paths except mem_ready and zero gating.
- Reset: async on rst_n low. State goes to FETCH (0). While rst_n = 0, irwrite, regwrite, memwrite and pcen are forced to 0. Select outputs hold their FETCH values.
- Reset asserted mid-instruction abandons the instruction. No partial write is completed after reset assertion.
- States and transitions:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, alu_op=00, pcsrc=00.
    - irwrite = pcen = mem_ready.
    - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
  - DECODE(1): alusrca=0, alusrcb=11, alu_op=00. Next state by opcode:
    - LW 100011 / SW 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - BEQ 000100 -> BRANCH
    - ADDI 001000 -> ADDIEX
    - J 000010 -> JUMP
    - any other opcode -> FETCH (treated as NOP; no write).
  - MEMADR(2): alusrca=1, alusrcb=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): iord=1. Stays while mem_ready=0; goes to MEMWB when mem_ready=1.
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next FETCH.
  - MEMWR(5): iord=1, memwrite=1. Stays until mem_ready=1, then FETCH.
    - memwrite stays high for every stalled cycle.
  - EXECUTE(6): alusrca=1, alusrcb=00, alu_op=10. Next ALUWB.
  - ALUWB(7): regdst=1, memtoreg=0, regwrite=1. Next FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, alu_op=01, pcsrc=01, branch=1. Next FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, alu_op=00. Next ADDIWB.
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Next FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. Next FETCH.
  - Unused encodings 12-15 -> FETCH, all enables 0.
- Unlisted outputs in each state are 0.
- Enables must be exactly 1 cycle wide, except stall-extended memwrite.
- Latency with mem_ready always 1:
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, J: 3 cycles.
- opcode is sampled only in DECODE and MEMADR. The IR is stable there because irwrite=0.

Decomposition:
- Package mc_pkg holds:
  - state localparams (FETCH..JUMP, STW wide)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - alusrcb, pcsrc and alu_op encodings; the ALU decoder shares the alu_op encodings.
- Single module, no sub-module.
- Next-state logic, state register and output decode live in three always blocks in the same file.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with mem_ready=1 -> state_o=0 throughout reset, irwrite=pcen=0 during reset; first post-reset cycle has irwrite=1, pcen=1, alusrcb=01.
- LW (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1, regdst=0; total 5 cycles.
- SW with mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles, memwrite=1 all 3 cycles, iord=1, then FETCH; regwrite never asserted.
- BEQ with zero=1 -> pcen=1, pcsrc=01, alu_op=01 in state 8. Repeat with zero=0 -> pcen=0 in state 8.
- R-type then ADDI then J back to back -> state sequences 0,1,6,7 / 0,1,9,10 / 0,1,11. regdst=1 in ALUWB, regdst=0 in ADDIWB, pcsrc=10 with pcen=1 in JUMP.
- Illegal opcode 111111 in DECODE -> next state FETCH, no enable asserted. Also assert rst_n low during MEMRD -> immediate return to 0 with no regwrite pulse.
